// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin IF/LSB arbiter that serialises 1/2/4-byte accesses onto a byte-wide RAM port.
// Optional build macro MEM_IO_STALL_EN adds io_buffer_full to hold off stores to the IO window.
module mem_arbiter #(
    parameter int unsigned       ADDR_W  = 32,
    parameter logic [ADDR_W-1:0] IO_BASE = 32'h00030000
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              flush_in,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ready,
    output logic [31:0]       if_data,
    input  logic              lsb_req,
    input  logic              lsb_wr,
    input  logic [1:0]        lsb_size,
    input  logic [ADDR_W-1:0] lsb_addr,
    input  logic [31:0]       lsb_wdata,
`ifdef MEM_IO_STALL_EN
    input  logic              io_buffer_full,
`endif
    output logic              lsb_ready,
    output logic [31:0]       lsb_rdata,
    input  logic [7:0]        mem_din,
    output logic [7:0]        mem_dout,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr
);

    typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;
    typedef enum logic {GNT_IF, GNT_LSB} grant_t;

    state_t            state_q, state_n;
    grant_t            last_q, last_n;
    logic [2:0]        cnt_q, cnt_n;
    logic [2:0]        nb_q, nb_n;
    logic [ADDR_W-1:0] addr_q, addr_n;
    logic [31:0]       wdata_q, wdata_n;
    logic [31:0]       data_q, data_n;
    logic              if_ready_n, lsb_ready_n, mem_wr_n;
    logic [31:0]       if_data_n, lsb_rdata_n;
    logic [7:0]        mem_dout_n;
    logic [ADDR_W-1:0] mem_a_n;

    logic       io_hit, io_stall, lsb_ok, pick_lsb;
    logic [2:0] nxt_cnt;
    logic [1:0] cap_idx;

`ifdef MEM_IO_STALL_EN
    assign io_stall = io_buffer_full;
`else
    assign io_stall = 1'b0;
`endif
    assign io_hit  = lsb_wr && (lsb_addr == IO_BASE || lsb_addr == IO_BASE + ADDR_W'(4));
    assign lsb_ok  = lsb_req && !(io_hit && io_stall);
    assign nxt_cnt = cnt_q + 3'd1;
    assign cap_idx = 2'(cnt_q - 3'd1);

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q   <= IDLE;
            last_q    <= GNT_IF;
            cnt_q     <= '0;
            nb_q      <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            data_q    <= '0;
            if_ready  <= 1'b0;
            if_data   <= '0;
            lsb_ready <= 1'b0;
            lsb_rdata <= '0;
            mem_dout  <= '0;
            mem_a     <= '0;
            mem_wr    <= 1'b0;
        end else if (rdy_in) begin
            state_q   <= state_n;
            last_q    <= last_n;
            cnt_q     <= cnt_n;
            nb_q      <= nb_n;
            addr_q    <= addr_n;
            wdata_q   <= wdata_n;
            data_q    <= data_n;
            if_ready  <= if_ready_n;
            if_data   <= if_data_n;
            lsb_ready <= lsb_ready_n;
            lsb_rdata <= lsb_rdata_n;
            mem_dout  <= mem_dout_n;
            mem_a     <= mem_a_n;
            mem_wr    <= mem_wr_n;
        end
    end

    always_comb begin
        state_n     = state_q;
        last_n      = last_q;
        cnt_n       = cnt_q;
        nb_n        = nb_q;
        addr_n      = addr_q;
        wdata_n     = wdata_q;
        data_n      = data_q;
        if_ready_n  = 1'b0;
        lsb_ready_n = 1'b0;
        if_data_n   = if_data;
        lsb_rdata_n = lsb_rdata;
        mem_dout_n  = mem_dout;
        mem_a_n     = mem_a;
        mem_wr_n    = mem_wr;
        pick_lsb    = 1'b0;

        case (state_q)
            IDLE: begin
                mem_a_n    = '0;
                mem_wr_n   = 1'b0;
                mem_dout_n = '0;
                // a ready pulse in the previous cycle blocks the grant so the served requester can drop req
                if (!flush_in && !if_ready && !lsb_ready && (if_req || lsb_ok)) begin
                    pick_lsb = lsb_ok && (!if_req || last_q == GNT_IF);
                    cnt_n    = '0;
                    data_n   = '0;
                    if (pick_lsb) begin
                        last_n  = GNT_LSB;
                        addr_n  = lsb_addr;
                        wdata_n = lsb_wdata;
                        case (lsb_size)
                            2'd0:    nb_n = 3'd1;
                            2'd1:    nb_n = 3'd2;
                            default: nb_n = 3'd4;
                        endcase
                        state_n    = lsb_wr ? WRITE : READ;
                        mem_a_n    = lsb_addr;
                        mem_wr_n   = lsb_wr;
                        mem_dout_n = lsb_wr ? lsb_wdata[7:0] : 8'h00;
                    end else begin
                        last_n  = GNT_IF;
                        addr_n  = if_addr;
                        nb_n    = 3'd4;
                        state_n = READ;
                        mem_a_n = if_addr;
                    end
                end
            end
            READ: begin
                if (flush_in) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                    mem_a_n = '0;
                end else begin
                    // byte k arrives two edges after its address was issued
                    if (cnt_q != 3'd0)
                        data_n[{cap_idx, 3'b000} +: 8] = mem_din;
                    if (cnt_q == nb_q) begin
                        state_n = IDLE;
                        cnt_n   = '0;
                        mem_a_n = '0;
                        if (last_q == GNT_IF) begin
                            if_ready_n = 1'b1;
                            if_data_n  = data_n;
                        end else begin
                            lsb_ready_n = 1'b1;
                            lsb_rdata_n = data_n;
                        end
                    end else begin
                        cnt_n   = nxt_cnt;
                        mem_a_n = (nxt_cnt < nb_q) ? addr_q + ADDR_W'(nxt_cnt) : '0;
                    end
                end
            end
            WRITE: begin
                if (nxt_cnt < nb_q) begin
                    cnt_n      = nxt_cnt;
                    mem_a_n    = addr_q + ADDR_W'(nxt_cnt);
                    mem_dout_n = wdata_q[{nxt_cnt[1:0], 3'b000} +: 8];
                    mem_wr_n   = 1'b1;
                end else begin
                    state_n     = IDLE;
                    cnt_n       = '0;
                    mem_a_n     = '0;
                    mem_dout_n  = '0;
                    mem_wr_n    = 1'b0;
                    lsb_ready_n = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: table-driven vectors plus directed sequences for arbitration, flush, pause and reset.
// Build with MEM_IO_STALL_EN defined to include the IO-store hold-off sequence.
module tb_mem_arbiter;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b0;
    logic        rdy_in = 1'b1;
    logic        flush_in = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_ready;
    logic [31:0] if_data;
    logic        lsb_req = 1'b0;
    logic        lsb_wr = 1'b0;
    logic [1:0]  lsb_size = '0;
    logic [31:0] lsb_addr = '0;
    logic [31:0] lsb_wdata = '0;
    logic        lsb_ready;
    logic [31:0] lsb_rdata;
    logic [7:0]  mem_din = '0;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
`ifdef MEM_IO_STALL_EN
    logic        io_buffer_full = 1'b0;
`endif

    int total = 0;
    int bad   = 0;
    logic [7:0] ram [0:4095];

    mem_arbiter #(.ADDR_W(32), .IO_BASE(32'h00030000)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
        .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_data(if_data),
        .lsb_req(lsb_req), .lsb_wr(lsb_wr), .lsb_size(lsb_size), .lsb_addr(lsb_addr),
        .lsb_wdata(lsb_wdata),
`ifdef MEM_IO_STALL_EN
        .io_buffer_full(io_buffer_full),
`endif
        .lsb_ready(lsb_ready), .lsb_rdata(lsb_rdata),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr)
    );

    always #5 clk_in = ~clk_in;

    // read-only RAM with one cycle of latency, paused together with the arbiter
    always @(posedge clk_in) if (rdy_in) mem_din <= ram[mem_a[11:0]];

    typedef struct {
        bit          is_if;
        bit          wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rbytes;
        bit          flush;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int n, lat, other;
        bit got;
        n = v.is_if ? 4 : (v.size == 2'd0) ? 1 : (v.size == 2'd1) ? 2 : 4;
        for (int k = 0; k < 4; k++) ram[12'(v.addr + 32'(k))] = v.rbytes[8*k +: 8];
        @(negedge clk_in);
        if (v.is_if) begin
            if_req = 1'b1; if_addr = v.addr;
        end else begin
            lsb_req = 1'b1; lsb_wr = v.wr; lsb_size = v.size;
            lsb_addr = v.addr; lsb_wdata = v.wdata;
        end
        @(posedge clk_in); #1;
        got = 1'b0; lat = -1; other = 0;
        for (int e = 0; e < 20 && !got; e++) begin
            if (e > 0) begin @(posedge clk_in); #1; end
            if (v.flush && e == 0) flush_in = 1'b1;
            if (e < n) begin
                chk($sformatf("v%0d_a%0d", idx, e), mem_a, v.addr + 32'(e));
                chk($sformatf("v%0d_wr%0d", idx, e), 32'(mem_wr), 32'(v.wr));
                if (v.wr) chk($sformatf("v%0d_dout%0d", idx, e), 32'(mem_dout), 32'(v.wdata[8*e +: 8]));
            end else if (!v.wr && e == n) begin
                chk($sformatf("v%0d_a_cap", idx), mem_a, 32'h0);
            end
            if (v.is_if ? lsb_ready : if_ready) other++;
            if (v.is_if ? if_ready : lsb_ready) begin got = 1'b1; lat = e; end
        end
        flush_in = 1'b0; if_req = 1'b0; lsb_req = 1'b0;
        chk($sformatf("v%0d_lat", idx), 32'(lat), 32'(v.wr ? n : n + 1));
        if (!v.wr) chk($sformatf("v%0d_data", idx), v.is_if ? if_data : lsb_rdata, v.exp_data);
        chk($sformatf("v%0d_other_rdy", idx), 32'(other), 32'h0);
        @(posedge clk_in); #1;
        chk($sformatf("v%0d_rdy_drop", idx), 32'({if_ready, lsb_ready, mem_wr}), 32'h0);
        chk($sformatf("v%0d_idle_a", idx), mem_a, 32'h0);
    endtask

    initial begin : main
        int order [3];
        int n_served, seen, lat, n_if, n_lsb, n_wr;
        bit pend, reraised, got;

        for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
        vecs[0] = '{1'b1, 1'b0, 2'd2, 32'h0000_0010, 32'h0,         32'h0000_0513, 1'b0, 32'h0000_0513};
        vecs[1] = '{1'b0, 1'b1, 2'd2, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0,         1'b0, 32'h0};
        vecs[2] = '{1'b0, 1'b0, 2'd1, 32'h0000_0200, 32'h0,         32'h5566_1234, 1'b0, 32'h0000_1234};
        vecs[3] = '{1'b0, 1'b0, 2'd0, 32'h0000_0205, 32'h0,         32'h7788_999A, 1'b0, 32'h0000_009A};
        vecs[4] = '{1'b0, 1'b1, 2'd0, 32'h0000_0300, 32'h1122_3344, 32'h0,         1'b0, 32'h0};
        vecs[5] = '{1'b0, 1'b0, 2'd3, 32'h0000_0400, 32'h0,         32'h0403_0201, 1'b0, 32'h0403_0201};
        vecs[6] = '{1'b0, 1'b1, 2'd1, 32'h0000_0500, 32'hCAFE_BABE, 32'h0,         1'b0, 32'h0};
        vecs[7] = '{1'b0, 1'b0, 2'd2, 32'hFFFF_FFFE, 32'h0,         32'hA1B2_C3D4, 1'b0, 32'hA1B2_C3D4};
        vecs[8] = '{1'b0, 1'b1, 2'd2, 32'h0000_0600, 32'h0102_0304, 32'h0,         1'b1, 32'h0};
        vecs[9] = '{1'b1, 1'b0, 2'd2, 32'h0000_0020, 32'h0,         32'hCAFE_D00D, 1'b0, 32'hCAFE_D00D};

        // reset values
        #12;
        chk("rst_if_ready", 32'(if_ready), 32'h0);
        chk("rst_if_data", if_data, 32'h0);
        chk("rst_lsb_ready", 32'(lsb_ready), 32'h0);
        chk("rst_lsb_rdata", lsb_rdata, 32'h0);
        chk("rst_mem_a", mem_a, 32'h0);
        chk("rst_mem_wr_dout", 32'({mem_wr, mem_dout}), 32'h0);
        @(negedge clk_in); rst_in = 1'b1;

        // arbitration: first tie goes to LSB; LSB re-requests at once so the next tie goes to IF
        for (int k = 0; k < 4; k++) begin
            ram[12'(32'h20 + 32'(k))] = 8'(32'h1122_3344 >> (8*k));
            ram[12'(32'h40 + 32'(k))] = 8'(32'h5566_7788 >> (8*k));
        end
        @(negedge clk_in);
        if_req = 1'b1; if_addr = 32'h20;
        lsb_req = 1'b1; lsb_wr = 1'b0; lsb_size = 2'd2; lsb_addr = 32'h40;
        n_served = 0; pend = 1'b0; reraised = 1'b0;
        for (int c = 0; c < 60 && n_served < 3; c++) begin
            @(posedge clk_in); #1;
            if (pend) begin lsb_req = 1'b1; pend = 1'b0; end
            if (lsb_ready) begin
                order[n_served] = 1; n_served++;
                lsb_req = 1'b0;
                chk("arb_lsb_data", lsb_rdata, 32'h5566_7788);
                if (!reraised) begin pend = 1'b1; reraised = 1'b1; end
            end
            if (if_ready) begin
                order[n_served] = 0; n_served++;
                if_req = 1'b0;
                chk("arb_if_data", if_data, 32'h1122_3344);
            end
        end
        chk("arb_served", 32'(n_served), 32'd3);
        chk("arb_first_lsb", 32'(order[0]), 32'd1);
        chk("arb_second_if", 32'(order[1]), 32'd0);
        chk("arb_third_lsb", 32'(order[2]), 32'd1);
        repeat (2) @(posedge clk_in);

        for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);
        chk("lsb_rdata_hold", lsb_rdata, 32'hA1B2_C3D4);

        // flush during the third byte of an IF read, then flush in IDLE blocks the grant
        @(negedge clk_in); if_req = 1'b1; if_addr = 32'h10;
        @(posedge clk_in); @(posedge clk_in); @(posedge clk_in); #1;
        chk("flush_pre_a", mem_a, 32'h12);
        @(negedge clk_in); flush_in = 1'b1;
        @(posedge clk_in); #1;
        chk("flush_abort_a", mem_a, 32'h0);
        seen = if_ready ? 1 : 0;
        @(posedge clk_in); #1;
        chk("flush_idle_nogrant", mem_a, 32'h0);
        if (if_ready) seen++;
        @(negedge clk_in); flush_in = 1'b0; if_req = 1'b0;
        repeat (8) begin @(posedge clk_in); #1; if (if_ready) seen++; end
        chk("flush_no_ready", 32'(seen), 32'h0);
        chk("flush_data_kept", if_data, 32'hCAFE_D00D);

        // rdy_in low mid-read holds everything; ready comes four active edges after resuming
        @(negedge clk_in); if_req = 1'b1; if_addr = 32'h10;
        @(posedge clk_in); @(posedge clk_in); #1;
        chk("pause_pre_a", mem_a, 32'h11);
        rdy_in = 1'b0;
        repeat (3) @(posedge clk_in); #1;
        chk("pause_hold_a", mem_a, 32'h11);
        chk("pause_hold_rdy", 32'(if_ready), 32'h0);
        rdy_in = 1'b1;
        got = 1'b0; lat = -1;
        for (int e = 1; e <= 12 && !got; e++) begin
            @(posedge clk_in); #1;
            if (if_ready) begin got = 1'b1; lat = e; end
        end
        if_req = 1'b0;
        chk("pause_lat", 32'(lat), 32'd4);
        chk("pause_data", if_data, 32'h0000_0513);
        repeat (2) @(posedge clk_in);

`ifdef MEM_IO_STALL_EN
        // IO store held off while the buffer is full; IF takes the slot, store follows once it drains
        io_buffer_full = 1'b1;
        @(negedge clk_in);
        lsb_req = 1'b1; lsb_wr = 1'b1; lsb_size = 2'd2; lsb_addr = 32'h0003_0000; lsb_wdata = 32'h0BAD_F00D;
        if_req = 1'b1; if_addr = 32'h20;
        n_if = 0; n_lsb = 0; n_wr = 0;
        for (int c = 0; c < 15; c++) begin
            @(posedge clk_in); #1;
            if (if_ready) begin n_if++; if_req = 1'b0; end
            if (lsb_ready) n_lsb++;
            if (mem_wr) n_wr++;
        end
        chk("io_if_served", 32'(n_if), 32'd1);
        chk("io_lsb_held", 32'(n_lsb), 32'd0);
        chk("io_no_write", 32'(n_wr), 32'd0);
        io_buffer_full = 1'b0;
        for (int c = 0; c < 15 && n_lsb == 0; c++) begin
            @(posedge clk_in); #1;
            if (mem_wr) n_wr++;
            if (lsb_ready) begin n_lsb++; lsb_req = 1'b0; end
        end
        lsb_req = 1'b0;
        chk("io_lsb_done", 32'(n_lsb), 32'd1);
        chk("io_write_bytes", 32'(n_wr), 32'd4);
        repeat (2) @(posedge clk_in);
`endif

        // asynchronous reset in the middle of a store
        @(negedge clk_in);
        lsb_req = 1'b1; lsb_wr = 1'b1; lsb_size = 2'd2; lsb_addr = 32'h700; lsb_wdata = 32'h8899_AABB;
        @(posedge clk_in); @(posedge clk_in); #1;
        chk("rst_mid_pre_wr", 32'(mem_wr), 32'h1);
        #2 rst_in = 1'b0;
        #1;
        chk("rst_mid_wr", 32'(mem_wr), 32'h0);
        chk("rst_mid_a", mem_a, 32'h0);
        lsb_req = 1'b0;
        @(negedge clk_in); rst_in = 1'b1;
        repeat (2) @(posedge clk_in);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Owns the single byte-wide RAM port and shares it between two requesters: the instruction fetch unit (IF) and the load/store buffer (LSB).
- Arbitrates round-robin between them.
- Serialises 1/2/4-byte accesses into byte cycles, assembles read data and returns a one-cycle ready pulse to the requester.
- Honours ROB flush: in-flight reads are aborted; a committed store is never torn.

Parameters:
- ADDR_W, 32, address width of requests and of mem_a.
- IO_BASE, 32'h00030000, base of the memory-mapped IO window (used only by the optional feature).

Ports:
- clk_in  in  1  system clock.
- rst_in  in  1  asynchronous, active-low reset (0 = reset).
- rdy_in  in  1  pause; all state holds while low.
- flush_in  in  1  ROB clear-up / misprediction flush.
- if_req  in  1  IF read request; level, held until if_ready.
- if_addr  in  32  IF word address.
- if_ready  out  1  one-cycle pulse; if_data valid.
- if_data  out  32  fetched word, little-endian.
- lsb_req  in  1  LSB request; level, held until lsb_ready.
- lsb_wr  in  1  1 = store, 0 = load.
- lsb_size  in  2  0 = 1 byte, 1 = 2 bytes, 2 = 4 bytes; 3 is illegal and treated as 2.
- lsb_addr  in  32  byte address.
- lsb_wdata  in  32  store data; low bytes are used.
- lsb_ready  out  1  one-cycle pulse; load done (lsb_rdata valid) or store done.
- lsb_rdata  out  32  load data, zero-extended; sign extension is done by the LSB.
- mem_din  in  8  RAM read byte.
- mem_dout  out  8  RAM write byte.
- mem_a  out  32  RAM byte address.
- mem_wr  out  1  1 = write.

Behaviour:
- Reset (rst_in = 0, asynchronous): all outputs are 0, FSM = IDLE, last_grant = IF, byte counter = 0, data register = 0.
- FSM states: IDLE, READ, WRITE.
  - While in IDLE: mem_a = 0, mem_wr = 0, mem_dout = 0.
- Grant: made at a clock edge in IDLE when rdy_in = 1, flush_in = 0, and neither ready output was high in the preceding cycle. That gap guarantees the requester has dropped req.
- Arbitration:
  - Only one requester: it wins.
  - Both requesting: the requester that is not last_grant wins. After reset the LSB therefore wins the first tie.
  - last_grant updates on every grant.
  - Request address, size and data are latched at the grant edge; later changes are ignored.
- Read of N bytes (IF: N = 4; LSB load: N = 1/2/4), grant edge g:
  - After edge g+k (k = 0..N-1): mem_a = addr + k.
  - RAM latency is 1 cycle: byte k is captured at edge g+k+2 into bits [8k+7:8k].
  - At edge g+N+1: the FSM returns to IDLE and the matching ready output = 1 for one cycle, with data stable.
  - Ready therefore appears 5 edges after the grant for a word read.
  - mem_a = 0 during the final capture-only cycle.
- Write of N bytes, grant edge g:
  - After edge g+k (k = 0..N-1): mem_a = addr + k, mem_dout = wdata[8k+7:8k], mem_wr = 1.
  - At edge g+N: mem_wr = 0, mem_a = 0, IDLE, lsb_ready = 1.
- Address arithmetic is 32-bit with wrap-around (addr + k mod 2^32).
- if_data / lsb_rdata hold their last value until the next completed read of that requester.
- flush_in = 1 at an edge:
  - In READ: abort. The FSM goes to IDLE, no ready pulse, mem_a = 0, partial data is discarded.
  - In WRITE: the flush is ignored; the store completes and pulses lsb_ready.
  - In IDLE: no grant at that edge.
- rdy_in = 0: FSM, counter, outputs and last_grant all hold; the RAM is paused by the same signal.

Optional Feature:
- Macro MEM_IO_STALL_EN.
- Defined:
  - Adds input io_buffer_full (1 bit).
  - An LSB store whose address is IO_BASE or IO_BASE+4 is not granted while io_buffer_full = 1. The IF request may be granted in its place regardless of last_grant.
  - Granted IO stores are unaffected by later changes of io_buffer_full.
- Not defined: the port is absent and IO stores arbitrate like any other store.

Test Plan:
- IF read: if_req, if_addr = 0x10, RAM bytes 13,05,00,00 -> mem_a 0x10..0x13, if_ready 5 edges after grant, if_data = 0x00000513, lsb_ready stays 0.
- Word store: lsb_wr = 1, size = 2, addr = 0x100, wdata = 0xDEADBEEF -> mem_wr = 1 for exactly 4 cycles, bytes EF,BE,AD,DE at 0x100..0x103, then lsb_ready pulse.
- Halfword load: addr = 0x200, RAM bytes 34,12 -> lsb_rdata = 0x00001234, lsb_ready 3 edges after grant.
- Arbitration after reset: if_req and lsb_req both high -> LSB served first, IF next; a second tie is served IF first.
- Flush: flush_in at the third byte of an IF read -> no if_ready, IDLE next cycle. Flush during a word store -> all 4 bytes written and lsb_ready pulses.
- Reset and stall: rst_in to 0 mid-write -> mem_wr = 0 without a clock edge. With MEM_IO_STALL_EN: store to 0x30000 while io_buffer_full = 1 is held off and IF is served; the store is granted once io_buffer_full = 0.
